// File: rtl/dds_axis_packer_pkg.sv
// Shared definitions for the DDS sample packer: control-register bit positions,
// packer FSM states and the stream data width helper.
package dds_axis_packer_pkg;

  localparam int CTRL_RST_BIT  = 0;
  localparam int CTRL_STRT_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } pk_state_t;

  // Stream data is the sample rounded up to whole bytes.
  function automatic int td_width(input int sig_width);
    return ((sig_width + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/dds_axis_packer_if.sv
// AXI4-Stream bundle carrying packed DDS samples (no TKEEP/TUSER).
interface dds_axis_packer_if #(
  parameter int TD_WIDTH = 16
);
  logic [TD_WIDTH-1:0] tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dds_axis_packer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear and occupancy output.
module dds_axis_packer_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       a_rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately left without reset; the head word is only
  // consumed while the FIFO is non-empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: all sequential state uses <= so every flop samples pre-edge values
  // no matter how the always blocks are ordered.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Pointer MSB distinguishes full from empty when the index bits coincide.
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dds_axis_packer.sv
// Captures DDS output samples after the core's pipeline delay, queues them and
// streams them out as AXI4-Stream with periodic and stop-time TLAST.
module dds_axis_packer
  import dds_axis_packer_pkg::*;
#(
  parameter int SIG_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CAP_DLY    = 2
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  input  logic [31:0]                   i_dds_ctrl_reg,
  input  logic [15:0]                   i_frame_len,
  input  logic                          i_sample_en,
  input  logic signed [SIG_WIDTH-1:0]   i_dds_signal,
  dds_axis_packer_if.master             m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic [31:0]                   o_frame_cnt
);
  localparam int TD_WIDTH = td_width(SIG_WIDTH);
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;

  pk_state_t            state;
  logic [CAP_DLY-1:0]   cap_sr;
  logic [15:0]          frame_len_q;
  logic [15:0]          beat_cnt;
  logic                 soft_rst;
  logic                 start;
  logic                 capture;
  logic                 last_flag;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [LVL_W-1:0]     fifo_level;
  logic [SIG_WIDTH:0]   fifo_rdata;
  logic [SIG_WIDTH-1:0] head_sample;
  logic                 head_last;
  logic                 unused_ctrl_bits;

  assign soft_rst         = i_dds_ctrl_reg[CTRL_RST_BIT];
  assign start            = i_dds_ctrl_reg[CTRL_STRT_BIT];
  assign unused_ctrl_bits = ^i_dds_ctrl_reg[31:2];

  assign capture   = cap_sr[CAP_DLY-1] && (state == RUN);
  assign last_flag = (frame_len_q != '0) && (beat_cnt == frame_len_q - 16'd1);
  // A capture that meets a full FIFO is dropped even if a pop happens this edge.
  assign fifo_push = capture && !fifo_full;
  assign fifo_pop  = m_axis.tvalid && m_axis.tready;

  dds_axis_packer_sync_fifo #(
    .WIDTH (SIG_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .clr     (soft_rst),
    .push    (fifo_push),
    .wdata   ({last_flag, i_dds_signal}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign head_sample = fifo_rdata[SIG_WIDTH-1:0];
  assign head_last   = fifo_rdata[SIG_WIDTH];

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : TD_WIDTH'($signed(head_sample));
  // Stopping closes a partial frame by marking the final queued beat as last.
  assign m_axis.tlast  = !fifo_empty &&
                         (head_last || ((state == DRAIN) && (fifo_level == LVL_W'(1))));

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state       <= IDLE;
      cap_sr      <= '0;
      frame_len_q <= '0;
      beat_cnt    <= '0;
      o_overflow  <= 1'b0;
      o_frame_cnt <= '0;
    end else if (soft_rst) begin
      state       <= IDLE;
      cap_sr      <= '0;
      frame_len_q <= '0;
      beat_cnt    <= '0;
      o_overflow  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      cap_sr[0] <= i_sample_en;
      for (int i = 1; i < CAP_DLY; i++) cap_sr[i] <= cap_sr[i-1];

      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          frame_len_q <= i_frame_len;
          beat_cnt    <= '0;
        end
        RUN:     if (!start)    state <= DRAIN;
        DRAIN:   if (fifo_empty) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (capture) begin
        if (fifo_full) o_overflow <= 1'b1;
        else           beat_cnt   <= last_flag ? '0 : beat_cnt + 16'd1;
      end

      if (fifo_pop && m_axis.tlast) o_frame_cnt <= o_frame_cnt + 32'd1;
    end
  end

  assign o_fifo_level = fifo_level;

endmodule
